// File: rtl/rrat_pkg.sv
// Shared retirement types: architectural/physical register sizes, index
// types and the commit/free request records passed between ROB, RRAT and
// free list.
package rrat_pkg;

  localparam int SS_DEF    = 2;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int AW        = $clog2(ARCH_REGS);
  localparam int PW        = $clog2(PHYS_REGS);

  typedef logic [AW-1:0] arch_reg_t;
  typedef logic [PW-1:0] phys_reg_t;

  typedef struct packed {
    logic      valid;
    phys_reg_t preg;
  } free_req_t;

  typedef struct packed {
    logic      valid;
    arch_reg_t rd_arch;
    phys_reg_t rd_phys;
  } commit_req_t;

endpackage

// File: rtl/rrat_if.sv
// Commit bundle from the ROB head plus the back-pressured free-register
// bundle toward the free list. The master drives commits and free_ready,
// the slave (the RRAT) drives commit_ready and the free outputs.
interface rrat_if #(
  parameter int SS = rrat_pkg::SS_DEF,
  parameter int AW = rrat_pkg::AW,
  parameter int PW = rrat_pkg::PW
);
  logic [SS-1:0]         commit_valid;
  logic [SS-1:0][AW-1:0] commit_rd_arch;
  logic [SS-1:0][PW-1:0] commit_rd_phys;
  logic                  commit_ready;
  logic [SS-1:0]         free_valid;
  logic [SS-1:0][PW-1:0] free_preg;
  logic                  free_ready;

  modport master (
    output commit_valid, commit_rd_arch, commit_rd_phys, free_ready,
    input  commit_ready, free_valid, free_preg
  );

  modport slave (
    input  commit_valid, commit_rd_arch, commit_rd_phys, free_ready,
    output commit_ready, free_valid, free_preg
  );
endinterface

// File: rtl/rrat_chk.sv
// Simulation-only protocol and invariant checks for the RRAT: contiguous
// commit slots, freshly allocated pregs never already mapped, and the retire
// counter only moving on an accepted group.
module rrat_chk #(
  parameter int SS        = 2,
  parameter int ARCH_REGS = 32,
  parameter int AW        = 5,
  parameter int PW        = 6
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         accept,
  input logic [SS-1:0]                commit_valid,
  input logic [SS-1:0][AW-1:0]        commit_rd_arch,
  input logic [SS-1:0][PW-1:0]        commit_rd_phys,
  input logic [ARCH_REGS-1:0][PW-1:0] map,
  input logic [63:0]                  retired_cnt
);

  function automatic logic preg_in_map(input logic [PW-1:0] preg,
                                       input logic [ARCH_REGS-1:0][PW-1:0] m);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < ARCH_REGS; j++) begin
      if (m[j] == preg) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Valid slots must form a run starting at slot 0; new pregs must be free.
  always @(posedge clk) begin
    if (!rst) begin
      assert ((commit_valid & (commit_valid + SS'(1))) == '0)
        else $error("rrat_chk: commit_valid has a gap: %b", commit_valid);
      if (accept) begin
        for (int i = 0; i < SS; i++) begin
          if (commit_valid[i] && (commit_rd_arch[i] != '0)) begin
            assert (!preg_in_map(commit_rd_phys[i], map))
              else $error("rrat_chk: slot %0d preg %0d already mapped", i, commit_rd_phys[i]);
          end
        end
      end
    end
  end

  // Retire counter is frozen across cycles without an accepted group.
  a_cnt_hold: assert property (@(posedge clk) disable iff (rst)
    !accept |=> (retired_cnt == $past(retired_cnt)));

endmodule

// File: rtl/rrat_free_stage.sv
// SS-wide registered valid/ready stage. Accepts a new entry when it is empty
// or when its current entry is being drained on the same edge, so a full
// pipeline runs without bubbles.
module rrat_free_stage #(
  parameter int SS = 2,
  parameter int PW = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SS-1:0]         load_valid,
  input  logic [SS-1:0][PW-1:0] load_preg,
  output logic                  can_load,
  output logic [SS-1:0]         out_valid,
  output logic [SS-1:0][PW-1:0] out_preg,
  input  logic                  out_ready
);
  logic [SS-1:0]         valid_r;
  logic [SS-1:0][PW-1:0] preg_r;

  // Room exists when nothing is pending or the pending entry leaves now.
  always_comb begin
    can_load = !(|valid_r) || out_ready;
  end

  // Load new entry, otherwise drop a drained entry, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      preg_r  <= '0;
    end else if (load) begin
      valid_r <= load_valid;
      preg_r  <= load_preg;
    end else if (out_ready) begin
      valid_r <= '0;
      preg_r  <= preg_r;
    end else begin
      valid_r <= valid_r;
      preg_r  <= preg_r;
    end
  end

  assign out_valid = valid_r;
  assign out_preg  = preg_r;
endmodule

// File: rtl/rrat.sv
// Retirement register alias table. Holds the committed arch->phys map and
// returns displaced pregs to the free list through a registered stage.
// Optional feature: define RRAT_MAP_OUT_EN to expose the map as arch_map_out.
module rrat #(
  parameter int SS        = rrat_pkg::SS_DEF,
  parameter int ARCH_REGS = rrat_pkg::ARCH_REGS,
  parameter int PHYS_REGS = rrat_pkg::PHYS_REGS
) (
  input  logic clk,
  input  logic rst,
  rrat_if.slave cif
`ifdef RRAT_MAP_OUT_EN
  ,
  output logic [ARCH_REGS-1:0][$clog2(PHYS_REGS)-1:0] arch_map_out
`else
`endif
);
  import rrat_pkg::*;

  localparam int LAW = $clog2(ARCH_REGS);
  localparam int LPW = $clog2(PHYS_REGS);

  logic [ARCH_REGS-1:0][LPW-1:0] map_r;
  logic [ARCH_REGS-1:0][LPW-1:0] run_map_s;
  logic [SS-1:0]                 slot_valid_s;
  logic [SS-1:0][LPW-1:0]        slot_preg_s;
  logic [63:0]                   retired_cnt_r;
  logic [63:0]                   pop_s;
  logic                          can_load_s;
  logic                          accept_s;

  // Walk slots in order so a later slot sees an earlier slot's new mapping.
  always_comb begin
    run_map_s    = map_r;
    slot_valid_s = '0;
    slot_preg_s  = '0;
    pop_s        = 64'd0;
    for (int i = 0; i < SS; i++) begin
      pop_s = pop_s + {63'd0, cif.commit_valid[i]};
      if (cif.commit_valid[i] && (cif.commit_rd_arch[i] != '0)) begin
        slot_valid_s[i]                    = 1'b1;
        slot_preg_s[i]                     = run_map_s[cif.commit_rd_arch[i]];
        run_map_s[cif.commit_rd_arch[i]]   = cif.commit_rd_phys[i];
      end else begin
        slot_valid_s[i] = 1'b0;
        slot_preg_s[i]  = '0;
      end
    end
  end

  // Whole group goes in only when the free stage has room.
  always_comb begin
    accept_s         = (|cif.commit_valid) && can_load_s;
    cif.commit_ready = can_load_s;
  end

  // Committed map and retire counter; reset to the identity mapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_r[i] <= LPW'(i);
      end
      retired_cnt_r <= 64'd0;
    end else if (accept_s) begin
      map_r         <= run_map_s;
      retired_cnt_r <= retired_cnt_r + pop_s;
    end else begin
      map_r         <= map_r;
      retired_cnt_r <= retired_cnt_r;
    end
  end

  rrat_free_stage #(.SS(SS), .PW(LPW)) u_free (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_s),
    .load_valid (slot_valid_s),
    .load_preg  (slot_preg_s),
    .can_load   (can_load_s),
    .out_valid  (cif.free_valid),
    .out_preg   (cif.free_preg),
    .out_ready  (cif.free_ready)
  );

`ifdef RRAT_MAP_OUT_EN
  assign arch_map_out = map_r;
`else
`endif

`ifndef SYNTHESIS
  rrat_chk #(.SS(SS), .ARCH_REGS(ARCH_REGS), .AW(LAW), .PW(LPW)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .accept         (accept_s),
    .commit_valid   (cif.commit_valid),
    .commit_rd_arch (cif.commit_rd_arch),
    .commit_rd_phys (cif.commit_rd_phys),
    .map            (map_r),
    .retired_cnt    (retired_cnt_r)
  );
`else
`endif
endmodule

// File: tb/tb_rrat.sv
// Directed self-checking bench for rrat: reset state, single and dual
// commits, x0 handling, back-pressure, drain+accept and mid-run reset.
module tb_rrat;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rrat_if #(.SS(2), .AW(5), .PW(6)) bus ();

`ifdef RRAT_MAP_OUT_EN
  logic [31:0][5:0] arch_map_out;
  rrat #(.SS(2), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk (clk), .rst (rst), .cif (bus), .arch_map_out (arch_map_out));
`else
  rrat #(.SS(2), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk (clk), .rst (rst), .cif (bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] map_at(input int idx);
`ifdef RRAT_MAP_OUT_EN
    return arch_map_out[idx];
`else
    return dut.map_r[idx];
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [5:0] p0,
                       input logic [4:0] a1, input logic [5:0] p1);
    bus.commit_valid      = v;
    bus.commit_rd_arch[0] = a0;
    bus.commit_rd_phys[0] = p0;
    bus.commit_rd_arch[1] = a1;
    bus.commit_rd_phys[1] = p1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.free_ready = 1'b1;
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_map7", 64'(map_at(7)), 64'd7);
    check("rst_map0", 64'(map_at(0)), 64'd0);
    check("rst_free_valid", 64'(bus.free_valid), 64'd0);
    check("rst_commit_ready", 64'(bus.commit_ready), 64'd1);

    // Single commit x5 -> p40
    drive(2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
    tick();
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    check("single_free_valid", 64'(bus.free_valid), 64'd1);
    check("single_free_preg0", 64'(bus.free_preg[0]), 64'd5);
    check("single_map5", 64'(map_at(5)), 64'd40);
    check("single_retired", dut.retired_cnt_r, 64'd1);
    tick();
    check("single_drained", 64'(bus.free_valid), 64'd0);

    // Dual commit to the same destination
    do_reset();
    drive(2'b11, 5'd5, 6'd40, 5'd5, 6'd41);
    tick();
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    check("dual_free_valid", 64'(bus.free_valid), 64'd3);
    check("dual_free_preg0", 64'(bus.free_preg[0]), 64'd5);
    check("dual_free_preg1", 64'(bus.free_preg[1]), 64'd40);
    check("dual_map5", 64'(map_at(5)), 64'd41);

    // x0 in slot0, x3 -> p50 in slot1
    do_reset();
    drive(2'b11, 5'd0, 6'd33, 5'd3, 6'd50);
    tick();
    check("x0_free_valid", 64'(bus.free_valid), 64'd2);
    check("x0_free_preg1", 64'(bus.free_preg[1]), 64'd3);
    check("x0_map0", 64'(map_at(0)), 64'd0);
    check("x0_map3", 64'(map_at(3)), 64'd50);

    // Back-pressure: pending free held, new group x7 -> p51 stalled
    bus.free_ready = 1'b0;
    drive(2'b01, 5'd7, 6'd51, 5'd0, 6'd0);
    #1;
    check("bp_ready_low", 64'(bus.commit_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_ready_hold", 64'(bus.commit_ready), 64'd0);
      check("bp_map7_hold", 64'(map_at(7)), 64'd7);
      check("bp_free_hold", 64'(bus.free_valid), 64'd2);
    end
    bus.free_ready = 1'b1;
    #1;
    check("bp_ready_rise", 64'(bus.commit_ready), 64'd1);
    tick();
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    check("bp_accept_valid", 64'(bus.free_valid), 64'd1);
    check("bp_accept_preg0", 64'(bus.free_preg[0]), 64'd7);
    check("bp_accept_map7", 64'(map_at(7)), 64'd51);

    // Back-to-back groups with free_ready high
    drive(2'b01, 5'd1, 6'd42, 5'd0, 6'd0);
    tick();
    check("b2b_first_preg", 64'(bus.free_preg[0]), 64'd1);
    drive(2'b01, 5'd2, 6'd43, 5'd0, 6'd0);
    #1;
    check("b2b_ready", 64'(bus.commit_ready), 64'd1);
    tick();
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    check("b2b_second_valid", 64'(bus.free_valid), 64'd1);
    check("b2b_second_preg", 64'(bus.free_preg[0]), 64'd2);
    check("b2b_map2", 64'(map_at(2)), 64'd43);

    // Reset while a free is pending and map[5] = 40
    do_reset();
    drive(2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
    tick();
    drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    bus.free_ready = 1'b0;
    check("mid_pending", 64'(bus.free_valid), 64'd1);
    check("mid_map5_set", 64'(map_at(5)), 64'd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_free_valid", 64'(bus.free_valid), 64'd0);
    check("mid_rst_map5", 64'(map_at(5)), 64'd5);
    check("mid_rst_ready", 64'(bus.commit_ready), 64'd1);
    check("mid_rst_retired", dut.retired_cnt_r, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
